// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer; sole source of datapath enables.
// Define SEQ_TIMEOUT_EN to enable the memory-ack wait counter and sticky timeout fault.
module instr_sequencer #(
   parameter int TIMEOUT = 16
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_run,
   input  logic [3:0] i_opcode,
   input  logic       i_imem_ack,
   input  logic       i_dmem_ack,
   output logic       o_imem_req,
   output logic       o_ir_load,
   output logic       o_dmem_req,
   output logic       o_dmem_we,
   output logic [1:0] o_alufunc,
   output logic       o_reg_we,
   output logic [1:0] o_wb_sel,
   output logic       o_pc_en,
   output logic       o_pc_jump,
   output logic       o_instr_done,
   output logic       o_busy,
   output logic       o_fault,
   output logic [2:0] o_state
);

   // Handshake: a request is held high until the cycle in which its ack is
   // sampled high; the ack edge completes the transfer and req drops next cycle.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5
   } state_t;

   localparam logic [1:0] CLS_ALU   = 2'b00;
   localparam logic [1:0] CLS_LOAD  = 2'b01;
   localparam logic [1:0] CLS_STORE = 2'b10;
   localparam logic [1:0] CLS_JUMP  = 2'b11;

   state_t     state_q, state_d;
   logic [3:0] op_q, op_d;
   logic       fault_q, fault_d;
   logic [1:0] cls;
   logic       end_instr;
   logic       timeout_hit;

   assign cls = op_q[3:2];

`ifdef SEQ_TIMEOUT_EN
   logic [7:0] wait_q, wait_d;

   // Counts ack-low cycles of the current request; any other cycle clears it,
   // so it is zero on every entry into FETCH or MEM.
   always_comb begin
      wait_d = 8'd0;
      if ((state_q == S_FETCH && !i_imem_ack) || (state_q == S_MEM && !i_dmem_ack))
         wait_d = wait_q + 8'd1;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) wait_q <= 8'd0;
      else         wait_q <= wait_d;
   end

   assign timeout_hit = (wait_q == 8'(TIMEOUT - 1));
`else
   logic [7:0] timeout_unused;
   assign timeout_unused = 8'(TIMEOUT);
   assign timeout_hit    = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         op_q    <= 4'd0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      fault_d      = fault_q;
      end_instr    = 1'b0;
      o_imem_req   = 1'b0;
      o_ir_load    = 1'b0;
      o_dmem_req   = 1'b0;
      o_dmem_we    = 1'b0;
      o_alufunc    = 2'b00;
      o_reg_we     = 1'b0;
      o_wb_sel     = 2'b00;
      o_pc_en      = 1'b0;
      o_pc_jump    = 1'b0;
      o_instr_done = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_run && !fault_q) state_d = S_FETCH;
         end
         S_FETCH: begin
            o_imem_req = 1'b1;
            if (i_imem_ack) begin
               o_ir_load = 1'b1;
               state_d   = S_DECODE;
            end else if (timeout_hit) begin
               fault_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_DECODE: begin
            op_d    = i_opcode;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            case (cls)
               CLS_ALU: begin
                  o_alufunc = op_q[1:0];
                  state_d   = S_WB;
               end
               CLS_LOAD, CLS_STORE: begin
                  state_d = S_MEM;
               end
               CLS_JUMP: begin
                  o_pc_en   = 1'b1;
                  o_pc_jump = 1'b1;
                  o_reg_we  = op_q[0];
                  o_wb_sel  = 2'b10;
                  end_instr = 1'b1;
               end
               default: state_d = S_IDLE;
            endcase
         end
         S_MEM: begin
            o_dmem_req = 1'b1;
            o_dmem_we  = (cls == CLS_STORE);
            if (i_dmem_ack) begin
               if (cls == CLS_LOAD) begin
                  state_d = S_WB;
               end else begin
                  o_pc_en   = 1'b1;
                  end_instr = 1'b1;
               end
            end else if (timeout_hit) begin
               fault_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_WB: begin
            o_reg_we  = 1'b1;
            o_wb_sel  = (cls == CLS_LOAD) ? 2'b01 : 2'b00;
            o_pc_en   = 1'b1;
            end_instr = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // An instruction always finishes; i_run only decides what follows it.
      if (end_instr) begin
         o_instr_done = 1'b1;
         state_d      = i_run ? S_FETCH : S_IDLE;
      end
   end

   assign o_busy  = (state_q != S_IDLE);
   assign o_fault = fault_q;
   assign o_state = state_q;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control sequencer for the CPU core. Walks each instruction through FETCH, DECODE, EXEC, MEM and WB, and handshakes with instruction and data memory. Drives PC update, IR load, register write-back and ALU function select from a latched 4-bit opcode. Sits between the memory interfaces and the datapath; the only source of datapath enables.

## Interface
- TIMEOUT, 16: max cycles a memory request may wait for ack before fault; legal 2..255.
- i_clk  input  1  rising-edge clock.
- i_reset  input  1  asynchronous, active-high reset.
- i_run  input  1  level; 1 = keep issuing instructions.
- i_opcode  input  4  opcode field from IR; valid from the DECODE cycle on.
- i_imem_ack  input  1  instruction memory ack, sampled in FETCH.
- i_dmem_ack  input  1  data memory ack, sampled in MEM.
- o_imem_req  output  1  instruction fetch request.
- o_ir_load  output  1  load IR (= FETCH & i_imem_ack).
- o_dmem_req  output  1  data memory request.
- o_dmem_we  output  1  data memory write (store).
- o_alufunc  output  2  ALU function select.
- o_reg_we  output  1  register file write enable.
- o_wb_sel  output  2  write-back source: 00 ALU, 01 memory, 10 link (PC+1).
- o_pc_en  output  1  PC update enable.
- o_pc_jump  output  1  PC loads jump target instead of PC+1 (qualifies o_pc_en).
- o_instr_done  output  1  one-cycle pulse in the last cycle of each instruction.
- o_busy  output  1  state != IDLE.
- o_fault  output  1  sticky memory-timeout flag.

## Operation
- Opcode classes (op_q[3:2]): 00 ALU, 01 LOAD, 10 STORE, 11 JUMP; op_q[0]=1 on JUMP = link.
- op_q: 4-bit register loaded from i_opcode in DECODE.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB. Outputs are Moore-decoded from state and op_q; o_ir_load and o_instr_done also depend on ack in the same cycle.
- IDLE: all outputs 0. Goes to FETCH when i_run=1 and o_fault=0.
- FETCH: o_imem_req=1. Goes to DECODE on i_imem_ack.
- DECODE: latches op_q. Goes to EXEC.
- EXEC, ALU class: o_alufunc=op_q[1:0]. Goes to WB.
- EXEC, LOAD or STORE class: o_alufunc=00 (address add). Goes to MEM.
- EXEC, JUMP class: o_pc_en=1, o_pc_jump=1, o_reg_we=op_q[0], o_wb_sel=10. Ends the instruction.
- MEM: o_dmem_req=1; o_dmem_we=1 for STORE. On i_dmem_ack, LOAD goes to WB; STORE sets o_pc_en=1 and ends.
- WB: o_reg_we=1; o_wb_sel=00 for ALU, 01 for LOAD; o_pc_en=1. Ends.
- End of instruction: o_instr_done=1. Next state is FETCH if i_run=1, else IDLE.
- i_run=0 never aborts an instruction in flight.
- o_pc_en and o_reg_we are never asserted outside the cycles listed above.

## Timing
- Reset (async, any state): state=IDLE, op_q=0, wait counter=0, o_fault=0, all outputs 0.
- Latency with ack in the first request cycle:
  - ALU: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - JUMP: 3 cycles.
- Each ack-wait cycle adds one cycle.
- Ack is ignored outside its own state. Req stays high until the ack edge, then drops next cycle.
- Wait counter, 8 bits:
  - Cleared on entry to FETCH or MEM.
  - Increments each FETCH or MEM cycle with ack low.
- Fault: ack low while counter == TIMEOUT-1 sets o_fault at that edge and forces IDLE with no PC or register update. An ack in the TIMEOUT-th cycle is accepted normally.
- o_fault holds until i_reset and blocks exit from IDLE.

## Configuration
- SEQ_TIMEOUT_EN defined: wait counter and fault logic as above.
- Not defined: no counter; FETCH and MEM wait indefinitely; o_fault tied to 0; TIMEOUT unused.

## Test plan
- Reset, i_run=1, acks tied high, opcode 0010 (ALU):
  - EXEC: o_alufunc=10.
  - WB: o_reg_we=1, o_wb_sel=00, o_pc_en=1, o_instr_done=1.
  - Period 4 cycles per instruction, back-to-back.
- LOAD 0100, dmem_ack delayed 3 cycles: o_dmem_req high 4 cycles, o_dmem_we=0, then WB with o_wb_sel=01; instruction takes 8 cycles.
- STORE 1000 then JUMP 1101:
  - STORE: o_dmem_we=1 with o_dmem_req; o_pc_en in the ack cycle; no o_reg_we.
  - JUMP: EXEC asserts o_pc_en, o_pc_jump, o_reg_we and o_wb_sel=10 together.
- Drop i_run during DECODE of an ALU op: instruction completes through WB, then IDLE with o_busy=0.
- SEQ_TIMEOUT_EN, TIMEOUT=16, i_imem_ack stuck low: o_fault=1 after 16 FETCH cycles, state IDLE, no o_pc_en. Stays IDLE with i_run=1 until i_reset. Ack in cycle 16 gives no fault.
- Assert i_reset mid-MEM: outputs go 0 immediately, without waiting for a clock edge. After release with i_run=1, the next cycle is FETCH.
